// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    // Width needed to hold values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Bits taken from the next word: a full word, or whatever the chain still needs.
    function automatic int unsigned word_bits(input int unsigned word_w,
                                              input int unsigned remaining);
        return (remaining < word_w) ? remaining : word_w;
    endfunction

endpackage

// File: rtl/ccff_piso.sv
// Parallel-in serial-out register; shifts left so the word's MSB leaves first.
module ccff_piso #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              msb
);

    logic [WORD_W-1:0] sr_q;

    always_ff @(posedge CK) begin
        if (RST) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= din;
        end else if (shift) begin
            sr_q <= sr_q << 1;
        end
    end

    assign msb = sr_q[WORD_W-1];

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams parallel configuration words MSB-first into a CHAIN_LEN-bit scan chain.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned CNT_W     = cnt_width(CHAIN_LEN)
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sc_d,
    output logic              sc_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_cnt
);

    localparam int unsigned      WL_W      = cnt_width(WORD_W);
    localparam logic [CNT_W-1:0] CHAIN_MAX = CNT_W'(CHAIN_LEN);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WL_W-1:0]   word_left_q, word_left_d;
    logic              din_ready_q, din_ready_d;
    logic              sc_en_q, sc_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic              shift_en;
    logic [31:0]       remaining;

    assign accept    = (state_q == StLoad) && din_valid && din_ready_q;
    assign shift_en  = (state_q == StShift);
    assign remaining = CHAIN_LEN - 32'(bit_cnt_q);

    ccff_piso #(
        .WORD_W(WORD_W)
    ) u_piso (
        .CK   (CK),
        .RST  (RST),
        .load (accept),
        .shift(shift_en),
        .din  (din),
        .msb  (sc_d)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_left_d = word_left_q;
        din_ready_d = din_ready_q;
        sc_en_d     = sc_en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StLoad;
                    bit_cnt_d   = '0;
                    busy_d      = 1'b1;
                    din_ready_d = 1'b1;
                end
            end
            StLoad: begin
                if (accept) begin
                    state_d     = StShift;
                    din_ready_d = 1'b0;
                    sc_en_d     = 1'b1;
                    word_left_d = WL_W'(word_bits(WORD_W, remaining));
                end
            end
            StShift: begin
                bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                word_left_d = word_left_q - WL_W'(1);
                // Last bit of this word leaves on this edge.
                if (word_left_q == WL_W'(1)) begin
                    sc_en_d = 1'b0;
                    if (bit_cnt_d == CHAIN_MAX) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = StLoad;
                        din_ready_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            word_left_q <= '0;
            din_ready_q <= 1'b0;
            sc_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_left_q <= word_left_d;
            din_ready_q <= din_ready_d;
            sc_en_q     <= sc_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign din_ready = din_ready_q;
    assign sc_en     = sc_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: one loader with a 16-bit chain, one with a 12-bit chain (partial last word).
module tb_ccff_chain_loader;

    logic       CK = 1'b0;
    logic       RST;
    logic       start;
    logic [7:0] din;
    logic       din_valid;

    logic       din_ready_a, sc_d_a, sc_en_a, busy_a, done_a;
    logic [4:0] bit_cnt_a;
    logic       din_ready_b, sc_d_b, sc_en_b, busy_b, done_b;
    logic [3:0] bit_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Chain model and event counters, updated at the shifting edge.
    logic        mon_clr;
    logic [63:0] chain_a, chain_b;
    int          en_cnt_a, en_cnt_b, done_cnt_a, done_cnt_b, acc_a;

    always #5 CK = ~CK;

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(16)) dut_a (
        .CK(CK), .RST(RST), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_a), .sc_d(sc_d_a), .sc_en(sc_en_a), .busy(busy_a),
        .done(done_a), .bit_cnt(bit_cnt_a)
    );

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(12)) dut_b (
        .CK(CK), .RST(RST), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_b), .sc_d(sc_d_b), .sc_en(sc_en_b), .busy(busy_b),
        .done(done_b), .bit_cnt(bit_cnt_b)
    );

    always @(posedge CK) begin
        if (mon_clr) begin
            chain_a <= '0; chain_b <= '0;
            en_cnt_a <= 0; en_cnt_b <= 0; done_cnt_a <= 0; done_cnt_b <= 0; acc_a <= 0;
        end else begin
            if (sc_en_a) begin
                chain_a  <= {chain_a[62:0], sc_d_a};
                en_cnt_a <= en_cnt_a + 1;
            end
            if (sc_en_b) begin
                chain_b  <= {chain_b[62:0], sc_d_b};
                en_cnt_b <= en_cnt_b + 1;
            end
            if (done_a) done_cnt_a <= done_cnt_a + 1;
            if (done_b) done_cnt_b <= done_cnt_b + 1;
            if (din_valid && din_ready_a) acc_a <= acc_a + 1;
        end
    end

    task automatic reset_dut();
        RST = 1'b1; start = 1'b0; din_valid = 1'b0; din = 8'h00; mon_clr = 1'b1;
        repeat (2) @(posedge CK);
        @(negedge CK);
        RST = 1'b0; mon_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++; if (din_ready_a !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready: got %b expected 0", din_ready_a); end
        n_checks++; if (sc_en_a !== 1'b0) begin n_fail++; $display("FAIL reset_sc_en: got %b expected 0", sc_en_a); end
        n_checks++; if (sc_d_a !== 1'b0) begin n_fail++; $display("FAIL reset_sc_d: got %b expected 0", sc_d_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_a); end
        n_checks++; if (bit_cnt_a !== 5'd0) begin n_fail++; $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt_a); end
    endtask

    task automatic test_basic();
        logic [18:0] hist;
        int          done_at;
        reset_dut();
        start = 1'b1; din = 8'hA5; din_valid = 1'b1;
        @(negedge CK);
        start = 1'b0;
        n_checks++; if (din_ready_a !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after_start: got %b expected 1", din_ready_a); end
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy_a); end
        n_checks++; if (sc_en_a !== 1'b0) begin n_fail++; $display("FAIL basic_no_en_in_load: got %b expected 0", sc_en_a); end
        @(negedge CK);
        din = 8'h3C;
        n_checks++; if (din_ready_a !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drop: got %b expected 0", din_ready_a); end
        hist = '0; done_at = -1;
        for (int i = 0; i < 19; i++) begin
            hist = {hist[17:0], sc_en_a};
            if (done_a && done_at < 0) done_at = i;
            if (i < 18) @(negedge CK);
        end
        din_valid = 1'b0;
        n_checks++; if (hist !== 19'b11111111_0_11111111_00) begin n_fail++; $display("FAIL basic_en_pattern: got %b expected 1111111101111111100", hist); end
        n_checks++; if (done_at !== 17) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 17", done_at); end
        n_checks++; if (chain_a[15:0] !== 16'hA53C) begin n_fail++; $display("FAIL basic_chain: got %h expected a53c", chain_a[15:0]); end
        n_checks++; if (en_cnt_a !== 16) begin n_fail++; $display("FAIL basic_en_count: got %0d expected 16", en_cnt_a); end
        n_checks++; if (done_cnt_a !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt_a); end
        n_checks++; if (bit_cnt_a !== 5'd16) begin n_fail++; $display("FAIL basic_bit_cnt: got %0d expected 16", bit_cnt_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy_a); end
    endtask

    task automatic test_partial();
        logic [14:0] hist;
        int          done_at;
        reset_dut();
        start = 1'b1; din = 8'hFF; din_valid = 1'b1;
        @(negedge CK);
        start = 1'b0;
        @(negedge CK);
        din = 8'hB7;
        hist = '0; done_at = -1;
        for (int i = 0; i < 15; i++) begin
            hist = {hist[13:0], sc_en_b};
            if (done_b && done_at < 0) done_at = i;
            if (i < 14) @(negedge CK);
        end
        din_valid = 1'b0;
        n_checks++; if (hist !== 15'b11111111_0_1111_00) begin n_fail++; $display("FAIL partial_en_pattern: got %b expected 111111110111100", hist); end
        n_checks++; if (done_at !== 13) begin n_fail++; $display("FAIL partial_done_cycle: got %0d expected 13", done_at); end
        n_checks++; if (chain_b[11:0] !== 12'hFFB) begin n_fail++; $display("FAIL partial_chain: got %h expected ffb", chain_b[11:0]); end
        n_checks++; if (en_cnt_b !== 12) begin n_fail++; $display("FAIL partial_en_count: got %0d expected 12", en_cnt_b); end
        n_checks++; if (done_cnt_b !== 1) begin n_fail++; $display("FAIL partial_done_count: got %0d expected 1", done_cnt_b); end
        n_checks++; if (bit_cnt_b !== 4'd12) begin n_fail++; $display("FAIL partial_bit_cnt: got %0d expected 12", bit_cnt_b); end
    endtask

    task automatic test_stall();
        logic stall_ok;
        reset_dut();
        start = 1'b1; din = 8'h81; din_valid = 1'b0;
        @(negedge CK);
        start = 1'b0;
        stall_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(din_ready_a === 1'b1 && sc_en_a === 1'b0 && bit_cnt_a === 5'd0)) stall_ok = 1'b0;
            @(negedge CK);
        end
        n_checks++; if (stall_ok !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got %b expected 1", stall_ok); end
        n_checks++; if (acc_a !== 0) begin n_fail++; $display("FAIL stall_no_accept: got %0d expected 0", acc_a); end
        din_valid = 1'b1;
        @(negedge CK);
        din_valid = 1'b0;
        n_checks++; if (sc_en_a !== 1'b1) begin n_fail++; $display("FAIL stall_resume_en: got %b expected 1", sc_en_a); end
        n_checks++; if (sc_d_a !== 1'b1) begin n_fail++; $display("FAIL stall_resume_d: got %b expected 1", sc_d_a); end
        repeat (8) @(negedge CK);
        n_checks++; if (din_ready_a !== 1'b1 || sc_en_a !== 1'b0) begin n_fail++; $display("FAIL stall_second_load: got ready=%b en=%b expected ready=1 en=0", din_ready_a, sc_en_a); end
        n_checks++; if (bit_cnt_a !== 5'd8) begin n_fail++; $display("FAIL stall_bit_cnt: got %0d expected 8", bit_cnt_a); end
        n_checks++; if (chain_a[7:0] !== 8'h81) begin n_fail++; $display("FAIL stall_chain: got %h expected 81", chain_a[7:0]); end
    endtask

    task automatic test_reset_mid();
        int found;
        int i;
        reset_dut();
        start = 1'b1; din = 8'hF0; din_valid = 1'b1;
        @(negedge CK);
        start = 1'b0;
        found = 0; i = 0;
        while (!found && i < 20) begin
            if (bit_cnt_a === 5'd5) found = 1;
            else begin @(negedge CK); i++; end
        end
        n_checks++; if (found !== 1) begin n_fail++; $display("FAIL midrst_reach5: got %0d expected 1", found); end
        RST = 1'b1; din_valid = 1'b0;
        @(negedge CK);
        RST = 1'b0;
        n_checks++; if ({din_ready_a, sc_en_a, sc_d_a, busy_a, done_a, bit_cnt_a} !== 10'd0) begin
            n_fail++; $display("FAIL midrst_outputs: got %b expected 0000000000", {din_ready_a, sc_en_a, sc_d_a, busy_a, done_a, bit_cnt_a});
        end
        repeat (10) @(negedge CK);
        n_checks++; if (done_cnt_a !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", done_cnt_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got %b expected 0", busy_a); end
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        n_checks++; if (bit_cnt_a !== 5'd0 || din_ready_a !== 1'b1) begin n_fail++; $display("FAIL midrst_restart: got cnt=%0d ready=%b expected cnt=0 ready=1", bit_cnt_a, din_ready_a); end
    endtask

    task automatic test_ignored();
        int i;
        reset_dut();
        din = 8'h11; din_valid = 1'b1;
        repeat (3) @(negedge CK);
        n_checks++; if (din_ready_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL ign_idle_valid: got ready=%b busy=%b expected 0 0", din_ready_a, busy_a); end
        n_checks++; if (acc_a !== 0) begin n_fail++; $display("FAIL ign_idle_accept: got %0d expected 0", acc_a); end
        start = 1'b1; din = 8'hC3;
        @(negedge CK);
        start = 1'b0;
        @(negedge CK);
        din = 8'h5A;
        @(negedge CK);
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        n_checks++; if (sc_en_a !== 1'b1) begin n_fail++; $display("FAIL ign_start_in_shift: got %b expected 1", sc_en_a); end
        i = 0;
        while (done_a !== 1'b1 && i < 40) begin @(negedge CK); i++; end
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL ign_done_timeout: got %b expected 1", done_a); end
        repeat (3) @(negedge CK);
        din_valid = 1'b0;
        n_checks++; if (chain_a[15:0] !== 16'hC35A) begin n_fail++; $display("FAIL ign_chain: got %h expected c35a", chain_a[15:0]); end
        n_checks++; if (en_cnt_a !== 16) begin n_fail++; $display("FAIL ign_en_count: got %0d expected 16", en_cnt_a); end
        n_checks++; if (done_cnt_a !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt_a); end
        n_checks++; if (acc_a !== 2) begin n_fail++; $display("FAIL ign_accepts: got %0d expected 2", acc_a); end
        n_checks++; if (busy_a !== 1'b0 || bit_cnt_a !== 5'd16) begin n_fail++; $display("FAIL ign_final: got busy=%b cnt=%0d expected busy=0 cnt=16", busy_a, bit_cnt_a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_stall();
        test_reset_mid();
        test_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
